// File: rtl/line_fill_memory.sv
// line_fill_memory: main-memory responder behind the direct-mapped cache.
// It serves one request at a time. A request is either a critical-word-first
// line-fill read burst or a byte-strobed write-through word write.
// The responder also keeps counters of completed fills and committed writes.
// Ports:
//   clk, rst (async, active-high)
//   req_valid/req_ready/req_write/req_addr/req_wdata/req_wstrb : request side
//   resp_valid/resp_data/resp_word/resp_last                   : read beats
//   write_done, addr_error                                     : one-cycle status pulses
//   total_reads, total_writes                                  : statistics (wrap mod 2^32)
// The byte store has no reset. Its power-up image (memory.list) is loaded by
// the platform's memory-load flow.
module line_fill_memory #(
  parameter int MEM_SIZE           = 1024,
  parameter int WORD_PER_LINE      = 4,
  parameter int WORD_PER_LINE_BITS = 2,
  parameter int READ_LATENCY       = 3,
  parameter int WRITE_LATENCY      = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          req_valid,
  output logic                          req_ready,
  input  logic                          req_write,
  input  logic [31:0]                   req_addr,
  input  logic [31:0]                   req_wdata,
  input  logic [3:0]                    req_wstrb,
  output logic                          resp_valid,
  output logic [31:0]                   resp_data,
  output logic [WORD_PER_LINE_BITS-1:0] resp_word,
  output logic                          resp_last,
  output logic                          write_done,
  output logic                          addr_error,
  output logic [31:0]                   total_reads,
  output logic [31:0]                   total_writes
);

  localparam int AW   = $clog2(MEM_SIZE);
  localparam int WB   = WORD_PER_LINE_BITS;
  localparam int LB   = WB + 2;  // byte-offset bits within a line
  localparam int MAXL = (READ_LATENCY > WRITE_LATENCY) ? READ_LATENCY : WRITE_LATENCY;
  localparam int CW   = $clog2(MAXL + 1);
  localparam logic [31:0]   LINE_MASK = 32'(4 * WORD_PER_LINE - 1);
  localparam logic [WB-1:0] LAST_BEAT = WB'(WORD_PER_LINE - 1);

  typedef enum logic [2:0] {
    IDLE, READ_WAIT, READ_BURST, WRITE_WAIT, WRITE_ACK, ERR
  } state_t;

  logic [7:0] mem [MEM_SIZE];

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WB-1:0]    beat_q, beat_d;
  logic [AW-1:2]    widx_q;          // latched word address; [LB-1:2] is the critical word
  logic [31:0]      wdata_q;
  logic [3:0]       wstrb_q;
  logic [31:0]      resp_data_q;
  logic [WB-1:0]    resp_word_q;
  logic [31:0]      total_reads_q, total_writes_q;

  logic             accept, rd_ok, wr_ok, load_beat, commit, fill_done;
  logic [32:0]      rd_end, wr_end;
  logic [WB-1:0]    word_d;
  logic [AW-1:LB]   line_d;
  logic [AW-1:0]    beat_addr;
  logic [31:0]      beat_rdata;

  // Range checks are 33 bits wide so that addresses near 2^32 cannot wrap into range.
  assign rd_end = {1'b0, req_addr & ~LINE_MASK} + {1'b0, LINE_MASK};
  assign wr_end = {1'b0, req_addr & 32'hFFFF_FFFC} + 33'd3;
  assign rd_ok  = rd_end < 33'(MEM_SIZE);
  assign wr_ok  = wr_end < 33'(MEM_SIZE);
  assign accept = req_valid && (state_q == IDLE);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    beat_d    = beat_q;
    word_d    = resp_word_q;
    line_d    = widx_q[AW-1:LB];
    load_beat = 1'b0;
    commit    = 1'b0;
    fill_done = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          if (req_write) begin
            if (wr_ok) begin
              state_d = WRITE_WAIT;
              cnt_d   = CW'(WRITE_LATENCY - 1);
            end else begin
              state_d = ERR;
            end
          end else if (rd_ok) begin
            if (READ_LATENCY == 1) begin
              // No wait state: the first beat is loaded straight from the request.
              state_d   = READ_BURST;
              beat_d    = '0;
              word_d    = req_addr[LB-1:2];
              line_d    = req_addr[AW-1:LB];
              load_beat = 1'b1;
            end else begin
              state_d = READ_WAIT;
              cnt_d   = CW'(READ_LATENCY - 1);
            end
          end else begin
            state_d = ERR;
          end
        end
      end
      READ_WAIT: begin
        if (cnt_q == '0) begin
          state_d   = READ_BURST;
          beat_d    = '0;
          word_d    = widx_q[LB-1:2];
          load_beat = 1'b1;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      READ_BURST: begin
        if (beat_q == LAST_BEAT) begin
          state_d   = IDLE;
          fill_done = 1'b1;
        end else begin
          beat_d    = beat_q + WB'(1);
          word_d    = resp_word_q + WB'(1);  // wraps at the line boundary
          load_beat = 1'b1;
        end
      end
      WRITE_WAIT: begin
        if (cnt_q == '0) begin
          state_d = WRITE_ACK;
          commit  = 1'b1;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      WRITE_ACK: state_d = IDLE;
      ERR:       state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  assign beat_addr  = {line_d, word_d, 2'b00};
  assign beat_rdata = {mem[beat_addr + AW'(3)], mem[beat_addr + AW'(2)],
                       mem[beat_addr + AW'(1)], mem[beat_addr]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      beat_q         <= '0;
      widx_q         <= '0;
      wdata_q        <= '0;
      wstrb_q        <= '0;
      resp_data_q    <= '0;
      resp_word_q    <= '0;
      total_reads_q  <= '0;
      total_writes_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      beat_q  <= beat_d;
      if (accept) begin
        widx_q  <= req_addr[AW-1:2];
        wdata_q <= req_wdata;
        wstrb_q <= req_wstrb;
      end
      if (load_beat) begin
        resp_word_q <= word_d;
        resp_data_q <= beat_rdata;
      end
      if (fill_done) total_reads_q  <= total_reads_q + 32'd1;
      if (commit)    total_writes_q <= total_writes_q + 32'd1;
    end
  end

  // Backing store: only strobed bytes change. A reset clears state_q, which
  // suppresses commit, so any pending write is dropped.
  always_ff @(posedge clk) begin
    if (commit) begin
      for (int k = 0; k < 4; k++) begin
        if (wstrb_q[k]) mem[{widx_q, 2'(k)}] <= wdata_q[8*k +: 8];
      end
    end
  end

  assign req_ready    = (state_q == IDLE);
  assign resp_valid   = (state_q == READ_BURST);
  assign resp_last    = (state_q == READ_BURST) && (beat_q == LAST_BEAT);
  assign resp_data    = resp_data_q;
  assign resp_word    = resp_word_q;
  assign write_done   = (state_q == WRITE_ACK);
  assign addr_error   = (state_q == ERR);
  assign total_reads  = total_reads_q;
  assign total_writes = total_writes_q;

endmodule

// File: doc/line_fill_memory.md
Name: line_fill_memory

Overview:
- Main-memory responder on the far side of the direct-mapped cache.
- Serves two request types, one outstanding request at a time:
  - Line-fill reads: WORD_PER_LINE words, critical-word-first burst, fixed latency.
  - Write-through single-word writes with byte strobes.
- Owns the byte-addressable backing store, initialised from memory.list, and keeps access statistics.

Parameters:
- MEM_SIZE, 1024, backing store size in bytes (byte-addressable, little-endian words).
- WORD_PER_LINE, 4, words per cache line (one burst).
- WORD_PER_LINE_BITS, 2, log2(WORD_PER_LINE).
- READ_LATENCY, 3, cycles from request acceptance to first read beat; must be >= 1.
- WRITE_LATENCY, 2, cycles from request acceptance to write commit; must be >= 1.

Ports:
- clk  input  1  clock, all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- req_valid  input  1  request present.
- req_ready  output  1  responder can accept; high only in IDLE.
- req_write  input  1  1 = word write, 0 = line-fill read.
- req_addr  input  32  byte address; bits [1:0] ignored.
- req_wdata  input  32  write data.
- req_wstrb  input  4  byte enables; bit k enables byte k (req_wdata[8k+7:8k]).
- resp_valid  output  1  read beat valid; no backpressure.
- resp_data  output  32  read beat data.
- resp_word  output  WORD_PER_LINE_BITS  word index within line of current beat.
- resp_last  output  1  final beat of burst.
- write_done  output  1  one-cycle pulse after write commit.
- addr_error  output  1  one-cycle pulse on out-of-range request.
- total_reads  output  32  completed line fills.
- total_writes  output  32  committed writes.

Behaviour:
- Reset (async, any state):
  - State goes to IDLE.
  - req_ready=1; resp_valid, resp_last, write_done, addr_error = 0.
  - resp_data=0, resp_word=0, total_reads=0, total_writes=0.
  - Memory contents are not reset. A pending uncommitted write is dropped.
- Acceptance: at a rising edge with req_valid && req_ready, latch req_write, req_addr, req_wdata, req_wstrb. req_valid while not IDLE is ignored, not queued.
- Address range check at acceptance:
  - Read: line base {req_addr[31:4],4'b0} + 4*WORD_PER_LINE - 1 must be < MEM_SIZE.
  - Write: {req_addr[31:2],2'b0} + 3 must be < MEM_SIZE.
  - Failure: go to ERR; addr_error=1 for exactly one cycle, no memory access, no counter change, then IDLE.
- FSM states: IDLE, READ_WAIT, READ_BURST, WRITE_WAIT, WRITE_ACK, ERR.
- Read path:
  - Acceptance edge N: load the latency counter with READ_LATENCY-1 and the start index with req_addr[3:2].
  - Counter 0 goes directly to READ_BURST; otherwise READ_WAIT, decrementing each cycle.
  - READ_BURST: resp_valid=1 for exactly WORD_PER_LINE consecutive cycles. The first beat is visible in the cycle starting at edge N+READ_LATENCY.
  - Beat i has resp_word = (start + i) mod WORD_PER_LINE, wrapping at the line boundary.
  - resp_data = {mem[a+3], mem[a+2], mem[a+1], mem[a]}, where a = line base + 4*resp_word.
  - resp_last=1 on beat WORD_PER_LINE-1 only.
  - total_reads increments on the edge ending the last beat; state returns to IDLE on that edge.
- Write path:
  - Acceptance edge N: go to WRITE_WAIT for WRITE_LATENCY-1 cycles; with WRITE_LATENCY=1 the commit happens at the first following edge.
  - Commit edge N+WRITE_LATENCY: write only the strobed bytes to mem[word base .. +3] and increment total_writes. req_wstrb=0 still commits and counts.
  - Then WRITE_ACK: write_done=1 for one cycle, then IDLE.
- Outputs resp_data/resp_word hold their last value when resp_valid=0.
- total_reads and total_writes wrap modulo 2^32.
- Reads issued after write_done see the written data.

Test Plan:
- Reset, write 0xDEADBEEF to 0x40 with wstrb 4'b1111, accepted at edge N:
  - write_done high in the cycle after edge N+2; total_writes=1.
  - Line-fill read of 0x40 returns word0 = 0xDEADBEEF.
- Read 0x48, READ_LATENCY=3, accepted at edge N:
  - resp_valid high from edge N+3 for 4 cycles.
  - resp_word sequence 2,3,0,1; resp_last only on the word-1 beat.
  - total_reads +1.
- Byte strobe: write 0x000000AA to 0x40 with wstrb 4'b0001 after the first test -> subsequent read word0 = 0xDEADBEAA.
- Out of range: read 0x3F8 (line base 0x3F0, in range) -> normal burst; read 0x400 -> addr_error one cycle, no resp_valid, counters unchanged.
- Busy: hold req_valid=1 with a write during a read burst -> req_ready=0, write accepted only after return to IDLE, one write_done total.
- Reset mid-write: assert rst one cycle after acceptance with WRITE_LATENCY=2 -> memory word unchanged, no write_done, all counters 0, req_ready=1.
